// File: rtl/fp_mac_pkg.sv
// Shared FP32 constants and helpers for the MAC-unit accumulation path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fp_mac_pkg;

    localparam int FP32_W     = 32;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;

    localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

    // Index width for n items, never narrower than one bit so a
    // single-entry configuration still yields a legal vector.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp32_adder_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from ptr upward, wrapping to 0.
// Latency: grant is combinational from req; ptr updates on the edge after advance.
// Backpressure: ptr only moves when the caller reports an accepted grant (advance).
module rr_arbiter
    import fp_mac_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic [IDW-1:0] ptr
);

    // First requester at or after ptr in circular order wins.
    always_comb begin : search
        int   cand;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    // Pointer moves just past the winner, only when its handshake completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            if (grant_idx == IDW'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp32_adder_arbiter.sv
// Shares one combinational FP32 adder among NREQ valid/ready requesters, round-robin.
// Latency: accept at edge N -> rsp_valid after edge N+1; one result per cycle sustained.
// Backpressure: rsp_ready low holds OUT, then S1; req_ready drops only when both are full.
module fp32_adder_arbiter
    import fp_mac_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = FP32_W,
    parameter  int TAGW = 4,
    localparam int IDW  = clog2_min1(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W-1:0]         add_sum,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic [TAGW-1:0]      rsp_tag,
    output logic                 busy
);

    typedef struct packed {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [IDW-1:0]  id;
        logic [TAGW-1:0] tag;
    } s1_t;

    s1_t            s1_q;
    s1_t            s1_d;
    logic           s1_vld;
    logic           out_vld;
    logic           out_adv;
    logic           s1_free;
    logic           accept;
    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_idx;
    logic [IDW-1:0]  rr_ptr;

    // S1 moves to OUT whenever OUT is empty or draining this cycle; S1 can
    // take a new request if it is empty or vacating. rsp_ready therefore
    // reaches req_ready combinationally, which keeps the pipe at full rate.
    assign out_adv   = s1_vld & (~out_vld | rsp_ready);
    assign s1_free   = ~s1_vld | out_adv;
    assign req_ready = arb_grant & {NREQ{s1_free & rst_n}};
    assign accept    = |(req_valid & req_ready);

    rr_arbiter #(
        .N(NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (accept),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .ptr       (rr_ptr)
    );

    // Mux the granted requester's operands and tag toward S1.
    always_comb begin
        s1_d     = '0;
        s1_d.a   = req_a[arb_idx*W +: W];
        s1_d.b   = req_b[arb_idx*W +: W];
        s1_d.id  = arb_idx;
        s1_d.tag = req_tag[arb_idx*TAGW +: TAGW];
    end

    // S1 register: loads on handshake, empties when it advances with nothing behind it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else if (accept) begin
            s1_vld <= 1'b1;
            s1_q   <= s1_d;
        end else if (out_adv) begin
            s1_vld <= 1'b0;
        end
    end

    assign add_a = s1_q.a;
    assign add_b = s1_q.b;

    // OUT register: captures the adder result; on drain without refill the
    // payload is left in place and only the valid flag clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_tag  <= '0;
        end else if (out_adv) begin
            out_vld  <= 1'b1;
            rsp_data <= add_sum;
            rsp_id   <= s1_q.id;
            rsp_tag  <= s1_q.tag;
        end else if (rsp_ready) begin
            out_vld  <= 1'b0;
        end
    end

    assign rsp_valid = out_vld;
    assign busy      = s1_vld | out_vld;

endmodule
